quiz_round_controller: RTL and testbench

QUIZ_ROUND_CONTROLLER -- requirements
Module: quiz_round_controller

---
 rtl/quiz_round_controller.sv | 211 +++++++++++++++++++++
 tb/tb_quiz_round_controller.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/quiz_round_controller.sv
// Two-player quiz round controller: synchronized active-low remote keys,
// round-robin tie-break, per-question lockout, timeout and result hold.
module quiz_round_controller #(
   parameter int RESULT_CYCLES = 50000000,
   parameter int ROUND_TIMEOUT = 500000000,
   parameter int WIN_SCORE     = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] min_hex_joy,
   input  logic [3:0] ans,
   output logic [3:0] q_idx,
   output logic [3:0] score_p1,
   output logic [3:0] score_p2,
   output logic       lock_p1,
   output logic       lock_p2,
   output logic [1:0] winner,
   output logic       beep,
   output logic       busy
);

   localparam int TW = $clog2(ROUND_TIMEOUT + 1);
   localparam int RW = $clog2(RESULT_CYCLES + 1);
   localparam logic [TW-1:0] TMR_LAST = TW'(ROUND_TIMEOUT - 1);
   localparam logic [RW-1:0] RES_LAST = RW'(RESULT_CYCLES - 1);
   localparam logic [3:0]    WIN      = 4'(WIN_SCORE);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ASK,
      S_RESULT,
      S_OVER
   } state_t;

   state_t        state_q, state_d;
   logic [7:0]    sync1_q, sync2_q, prev_q;
   logic [3:0]    q_idx_q, q_idx_d;
   logic [3:0]    s1_q, s1_d;
   logic [3:0]    s2_q, s2_d;
   logic          lk1_q, lk1_d;
   logic          lk2_q, lk2_d;
   logic [1:0]    win_q, win_d;
   logic          rr_q, rr_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic [RW-1:0] res_q, res_d;

   logic [3:0] ch1, ch2;
   logic       pr1, pr2, v1, v2, ok1, ok2, tie;
   logic       aw1, aw2, wr1, wr2;

   // Only a clean single-key nibble maps to a choice; anything else is 0.
   function automatic logic [3:0] choice_f(input logic [3:0] nib);
      case (nib)
         4'b0111: return 4'd1;
         4'b1011: return 4'd2;
         4'b1101: return 4'd3;
         4'b1110: return 4'd4;
         default: return 4'd0;
      endcase
   endfunction

   assign ch1 = choice_f(sync2_q[7:4]);
   assign ch2 = choice_f(sync2_q[3:0]);
   assign pr1 = (ch1 != 4'd0) && (prev_q[7:4] == 4'hF);
   assign pr2 = (ch2 != 4'd0) && (prev_q[3:0] == 4'hF);

   // Priority player is judged first; a wrong answer hands over the tie.
   always_comb begin
      v1  = pr1 && !lk1_q;
      v2  = pr2 && !lk2_q;
      ok1 = (ch1 == ans);
      ok2 = (ch2 == ans);
      tie = v1 && v2;
      aw1 = 1'b0;
      aw2 = 1'b0;
      wr1 = 1'b0;
      wr2 = 1'b0;
      if (tie && !rr_q) begin
         if (ok1) begin
            aw1 = 1'b1;
         end else begin
            wr1 = 1'b1;
            aw2 = ok2;
            wr2 = !ok2;
         end
      end else if (tie) begin
         if (ok2) begin
            aw2 = 1'b1;
         end else begin
            wr2 = 1'b1;
            aw1 = ok1;
            wr1 = !ok1;
         end
      end else if (v1) begin
         aw1 = ok1;
         wr1 = !ok1;
      end else if (v2) begin
         aw2 = ok2;
         wr2 = !ok2;
      end
   end

   always_comb begin
      state_d = state_q;
      q_idx_d = q_idx_q;
      s1_d    = s1_q;
      s2_d    = s2_q;
      lk1_d   = lk1_q;
      lk2_d   = lk2_q;
      win_d   = win_q;
      rr_d    = rr_q;
      tmr_d   = tmr_q;
      res_d   = res_q;
      unique case (state_q)
         S_IDLE, S_OVER: begin
            if (start) begin
               q_idx_d = 4'd0;
               s1_d    = 4'd0;
               s2_d    = 4'd0;
               lk1_d   = 1'b0;
               lk2_d   = 1'b0;
               win_d   = 2'd0;
               rr_d    = 1'b0;
               tmr_d   = '0;
               state_d = S_ASK;
            end
         end
         S_ASK: begin
            tmr_d = tmr_q + 1'b1;
            if ((lk1_q && lk2_q) || (tmr_q == TMR_LAST)) begin
               win_d   = 2'd0;
               res_d   = '0;
               state_d = S_RESULT;
            end else begin
               lk1_d = lk1_q | wr1;
               lk2_d = lk2_q | wr2;
               if (tie) rr_d = ~rr_q;
               if (aw1) begin
                  if (s1_q < WIN) s1_d = s1_q + 4'd1;
                  win_d   = 2'd1;
                  res_d   = '0;
                  state_d = S_RESULT;
               end else if (aw2) begin
                  if (s2_q < WIN) s2_d = s2_q + 4'd1;
                  win_d   = 2'd2;
                  res_d   = '0;
                  state_d = S_RESULT;
               end
            end
         end
         S_RESULT: begin
            res_d = res_q + 1'b1;
            if (res_q == RES_LAST) begin
               if ((s1_q == WIN) || (s2_q == WIN)) begin
                  state_d = S_OVER;
               end else begin
                  q_idx_d = (q_idx_q == 4'd9) ? 4'd0 : q_idx_q + 4'd1;
                  lk1_d   = 1'b0;
                  lk2_d   = 1'b0;
                  tmr_d   = '0;
                  state_d = S_ASK;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         sync1_q <= 8'hFF;
         sync2_q <= 8'hFF;
         prev_q  <= 8'hFF;
         q_idx_q <= 4'd0;
         s1_q    <= 4'd0;
         s2_q    <= 4'd0;
         lk1_q   <= 1'b0;
         lk2_q   <= 1'b0;
         win_q   <= 2'd0;
         rr_q    <= 1'b0;
         tmr_q   <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         sync1_q <= min_hex_joy;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         q_idx_q <= q_idx_d;
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         lk1_q   <= lk1_d;
         lk2_q   <= lk2_d;
         win_q   <= win_d;
         rr_q    <= rr_d;
         tmr_q   <= tmr_d;
         res_q   <= res_d;
      end
   end

   assign q_idx    = q_idx_q;
   assign score_p1 = s1_q;
   assign score_p2 = s2_q;
   assign lock_p1  = lk1_q;
   assign lock_p2  = lk2_q;
   assign winner   = win_q;
   assign beep     = (state_q == S_OVER);
   assign busy     = (state_q == S_ASK) || (state_q == S_RESULT);

endmodule

// File: tb/tb_quiz_round_controller.sv
// Directed bench for quiz_round_controller: vector table for scoring,
// lockout and ties, plus sequences for timeout wrap and mid-round reset.
module tb_quiz_round_controller;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] hex;
   logic [3:0] ans;
   logic [3:0] q_idx;
   logic [3:0] score_p1, score_p2;
   logic       lock_p1, lock_p2;
   logic [1:0] winner;
   logic       beep, busy;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [7:0] hex;
      logic [3:0] ans;
      int         hold;
      int         idle;
      logic [3:0] s1;
      logic [3:0] s2;
      logic [1:0] w;
      logic       l1;
      logic       l2;
      logic [3:0] q;
      logic       busy;
      logic       beep;
   } vec_t;

   vec_t tv[11];

   quiz_round_controller #(
      .RESULT_CYCLES(4),
      .ROUND_TIMEOUT(20),
      .WIN_SCORE(5)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .min_hex_joy(hex),
      .ans(ans),
      .q_idx(q_idx),
      .score_p1(score_p1),
      .score_p2(score_p2),
      .lock_p1(lock_p1),
      .lock_p2(lock_p2),
      .winner(winner),
      .beep(beep),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, " q_idx"}, 32'(q_idx), 0);
      chk({tag, " score_p1"}, 32'(score_p1), 0);
      chk({tag, " score_p2"}, 32'(score_p2), 0);
      chk({tag, " lock_p1"}, 32'(lock_p1), 0);
      chk({tag, " lock_p2"}, 32'(lock_p2), 0);
      chk({tag, " winner"}, 32'(winner), 0);
      chk({tag, " beep"}, 32'(beep), 0);
      chk({tag, " busy"}, 32'(busy), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      string nm;
      // hex, ans, hold, idle | s1 s2 w l1 l2 q busy beep
      tv[0]  = '{8'hDF, 4'd3, 3, 8, 4'd1, 4'd0, 2'd1, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0};
      tv[1]  = '{8'hF7, 4'd2, 3, 8, 4'd1, 4'd0, 2'd1, 1'b0, 1'b1, 4'd1, 1'b1, 1'b0};
      tv[2]  = '{8'hBF, 4'd2, 3, 8, 4'd2, 4'd0, 2'd1, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0};
      tv[3]  = '{8'hBB, 4'd2, 3, 8, 4'd3, 4'd0, 2'd1, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0};
      tv[4]  = '{8'hBB, 4'd2, 3, 8, 4'd3, 4'd1, 2'd2, 1'b0, 1'b0, 4'd4, 1'b1, 1'b0};
      tv[5]  = '{8'hBB, 4'd3, 3, 8, 4'd3, 4'd1, 2'd0, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0};
      tv[6]  = '{8'hD7, 4'd3, 3, 8, 4'd4, 4'd1, 2'd1, 1'b0, 1'b0, 4'd6, 1'b1, 1'b0};
      tv[7]  = '{8'hF7, 4'd4, 3, 1, 4'd4, 4'd1, 2'd1, 1'b0, 1'b1, 4'd6, 1'b1, 1'b0};
      tv[8]  = '{8'hFE, 4'd4, 3, 1, 4'd4, 4'd1, 2'd1, 1'b0, 1'b1, 4'd6, 1'b1, 1'b0};
      tv[9]  = '{8'h7F, 4'd1, 3, 8, 4'd5, 4'd1, 2'd1, 1'b0, 1'b1, 4'd6, 1'b0, 1'b1};
      tv[10] = '{8'hDF, 4'd3, 3, 4, 4'd5, 4'd1, 2'd1, 1'b0, 1'b1, 4'd6, 1'b0, 1'b1};

      rst   = 1'b0;
      start = 1'b0;
      hex   = 8'hFF;
      ans   = 4'd0;
      #2 rst = 1'b1;
      #1;
      chk_reset("por");
      tick();
      tick();
      rst = 1'b0;
      tick();
      tick();
      chk("idle waits busy", 32'(busy), 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start busy", 32'(busy), 1);
      chk("start q_idx", 32'(q_idx), 0);

      for (int i = 0; i < 11; i++) begin
         ans = tv[i].ans;
         hex = tv[i].hex;
         repeat (tv[i].hold) tick();
         hex = 8'hFF;
         repeat (tv[i].idle) tick();
         nm = $sformatf("vec%0d", i);
         chk({nm, " score_p1"}, 32'(score_p1), 32'(tv[i].s1));
         chk({nm, " score_p2"}, 32'(score_p2), 32'(tv[i].s2));
         chk({nm, " winner"}, 32'(winner), 32'(tv[i].w));
         chk({nm, " lock_p1"}, 32'(lock_p1), 32'(tv[i].l1));
         chk({nm, " lock_p2"}, 32'(lock_p2), 32'(tv[i].l2));
         chk({nm, " q_idx"}, 32'(q_idx), 32'(tv[i].q));
         chk({nm, " busy"}, 32'(busy), 32'(tv[i].busy));
         chk({nm, " beep"}, 32'(beep), 32'(tv[i].beep));
      end

      // restart from game over
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("restart score_p1", 32'(score_p1), 0);
      chk("restart score_p2", 32'(score_p2), 0);
      chk("restart q_idx", 32'(q_idx), 0);
      chk("restart beep", 32'(beep), 0);
      chk("restart winner", 32'(winner), 0);
      chk("restart busy", 32'(busy), 1);

      // score once, then let every question time out up to q_idx 9
      ans = 4'd3;
      hex = 8'hDF;
      repeat (3) tick();
      hex = 8'hFF;
      chk("pre-timeout winner", 32'(winner), 1);
      n = 0;
      while (q_idx != 4'd9 && n < 400) begin
         tick();
         n++;
      end
      chk("reach q9", 32'(q_idx), 9);
      chk("q9 winner", 32'(winner), 0);
      chk("q9 score_p1", 32'(score_p1), 1);
      n = 0;
      while (q_idx == 4'd9 && n < 100) begin
         tick();
         n++;
      end
      chk("timeout+result cycles", 32'(n), 24);
      chk("wrap q_idx", 32'(q_idx), 0);
      chk("wrap score_p1", 32'(score_p1), 1);
      chk("wrap score_p2", 32'(score_p2), 0);
      chk("wrap winner", 32'(winner), 0);
      chk("wrap busy", 32'(busy), 1);

      // reset asserted in the middle of RESULT
      ans = 4'd3;
      hex = 8'hDF;
      repeat (3) tick();
      hex = 8'hFF;
      tick();
      chk("in result score_p1", 32'(score_p1), 2);
      chk("in result busy", 32'(busy), 1);
      #2 rst = 1'b1;
      #1;
      chk_reset("mid-result rst");
      tick();
      tick();
      rst = 1'b0;
      repeat (10) tick();
      chk("post rst score_p1", 32'(score_p1), 0);
      chk("post rst busy", 32'(busy), 0);
      chk("post rst winner", 32'(winner), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
